// File: rtl/mem_stage.sv
// Memory stage: data-memory request/handshake FSM, store lane steering, load extraction, MEM/WB register.
// Optional MEM_RANDOM_LFSR_EN adds a free-running 32-bit Galois LFSR selected by wb_sel=11.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] write_data_mem,
    input  logic [31:0] instruction_mem,
    input  logic [1:0]  wb_sel_mem,
    input  logic [1:0]  read_width_mem,
    input  logic [4:0]  wrt_dst_mem,
    input  logic        reg_wrt_en_mem,
    input  logic        mem_wrt_en_mem,
    input  logic        rd_en_mem,
    input  logic        read_unsigned_mem,
    input  logic        random_mem,
    input  logic        rdi_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic [31:0] wb_data_wb,
    output logic [4:0]  wrt_dst_wb,
    output logic        reg_wrt_en_wb,
    output logic        rdi_wb,
    output logic [31:0] instruction_wb
);
    // Handshake: dmem_req stays high from issue until the cycle dmem_ack is seen;
    // that cycle completes the op and the EX/MEM register advances on the same edge.
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic        mem_op;
    logic [31:0] load_data;
    logic [31:0] rnd_value;
    logic [31:0] wb_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mem_op    = rd_en_mem | mem_wrt_en_mem;
    assign dmem_req  = rst_n & mem_op;
    assign dmem_we   = mem_wrt_en_mem;
    assign stall_mem = rst_n & mem_op & ~dmem_ack;
    assign dmem_addr = {alu_result_mem[31:2], 2'b00};

    // Misaligned halves use addr[1] only; words ignore the low address bits.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_mem;
        case (read_width_mem)
            2'b00: begin
                dmem_be    = 4'b0001 << alu_result_mem[1:0];
                dmem_wdata = {4{write_data_mem[7:0]}};
            end
            2'b01: begin
                dmem_be    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{write_data_mem[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = write_data_mem;
            end
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (alu_result_mem[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel  = alu_result_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (read_width_mem)
            2'b00:   load_data = read_unsigned_mem ? {24'd0, byte_sel}
                                                   : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = read_unsigned_mem ? {16'd0, half_sel}
                                                   : {{16{half_sel[15]}}, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

`ifdef MEM_RANDOM_LFSR_EN
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    logic [31:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
    end
    assign rnd_value = lfsr;
`else
    assign rnd_value = 32'd0;
`endif

    always_comb begin
        wb_next = alu_result_mem;
        case (wb_sel_mem)
            2'b00:   wb_next = alu_result_mem;
            2'b01:   wb_next = load_data;
            2'b10:   wb_next = next_pc_mem;
            default: wb_next = rnd_value;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (mem_op && !dmem_ack) state <= BUSY;
                BUSY:    if (dmem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled cycle pushes a bubble; payload fields are left as-is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_data_wb     <= 32'd0;
            wrt_dst_wb     <= 5'd0;
            reg_wrt_en_wb  <= 1'b0;
            rdi_wb         <= 1'b0;
            instruction_wb <= 32'd0;
        end else if (stall_mem) begin
            reg_wrt_en_wb  <= 1'b0;
            rdi_wb         <= 1'b0;
        end else begin
            wb_data_wb     <= wb_next;
            wrt_dst_wb     <= wrt_dst_mem;
            reg_wrt_en_wb  <= reg_wrt_en_mem;
            rdi_wb         <= rdi_mem;
            instruction_wb <= instruction_mem;
        end
    end

    logic unused_ok;
    assign unused_ok = random_mem;
endmodule
